back_icon_dispatcher: RTL and testbench
=======================================

# back_icon_dispatcher

Front-end-to-interconnect steering stage. It accepts up to NUM_DISPATCH_PORTS interconnect transfer instructions per cycle from decode/rename into an in-order staging FIFO. It drains the FIFO head into the per-channel instruction queues of back_icon_controller, up to one instruction per channel per cycle. Channel choice is round-robin over channels whose queue is not full.

## Interface
- NUM_ICON_CHANNELS, 4: channel count; must match back_icon_controller.
- NUM_DISPATCH_PORTS, 2: front-end instructions offered per cycle; 1..2^LOG2_STAGING_DEPTH.
- LOG2_STAGING_DEPTH, 3: staging FIFO holds 2^LOG2_STAGING_DEPTH entries.
- clk  in  1  clock; reset reset_n, synchronous, active-low.
- reset_n  in  1  synchronous active-low reset.
- fe_instr_i  in  type_icon_instr[NUM_DISPATCH_PORTS]  offered instructions; port 0 is oldest.
- fe_valid_i  in  1[NUM_DISPATCH_PORTS]  per-port valid; valid ports must be contiguous from port 0.
- fe_ready_o  out  1  all valid ports accepted this cycle when high.
- icon_instr_dispatch_o  out  type_icon_instr[NUM_ICON_CHANNELS]  to controller; all zeros when not valid.
- icon_instr_dispatch_valid_o  out  1[NUM_ICON_CHANNELS]  write strobe per channel queue.
- icon_instr_dispatch_ready_i  in  1[NUM_ICON_CHANNELS]  channel queue not full.
- channel_active_i  in  1[NUM_ICON_CHANNELS]  controller channel_active_o; used only by affinity mode.
- occupancy_o  out  LOG2_STAGING_DEPTH+1  staging FIFO entry count.

## Operation
- Staging FIFO: circular buffer with read pointer, write pointer and count.
  - Pointers wrap modulo 2^LOG2_STAGING_DEPTH.
  - Count ranges 0..2^LOG2_STAGING_DEPTH.
- Accept:
  - fe_ready_o = (2^LOG2_STAGING_DEPTH − count) ≥ NUM_DISPATCH_PORTS, computed from registered count only. There is no combinational path from fe_valid_i.
  - When fe_ready_o is high, every valid port is written in port order at consecutive write pointer positions.
  - Instructions with receiver_list == 0 are still accepted.
- Drain (combinational each cycle), walking FIFO entries from the head in order, up to min(count, NUM_ICON_CHANNELS) entries:
  - An entry with receiver_list == 0 is popped without being assigned to a channel.
  - Any other entry is assigned to the first channel that is ready and not yet used this cycle, searching from rr_ptr upward modulo NUM_ICON_CHANNELS.
  - The walk stops at the first entry that finds no channel. This keeps drain strictly in order.
- Popped entries = number of walked entries before the stop.
- rr_ptr update: set to (last assigned channel + 1) mod NUM_ICON_CHANNELS; unchanged if nothing was assigned.
- Push and pop in the same cycle: count_next = count + pushes − pops.
- Outputs for unassigned channels: valid 0, instruction all zeros.

## Timing
- Reset values: fe_ready_o 1 (count 0), all icon_instr_dispatch_valid_o 0, all icon_instr_dispatch_o zeros, occupancy_o 0, rr_ptr 0, affinity tags cleared.
- Reset mid-operation discards all staged entries with no dispatch on the reset cycle.
- Latency: an instruction accepted at edge N is presented at the earliest in cycle N+1 and written to the channel queue at edge N+1. There is no bypass path.
- Dispatch outputs are combinational from FIFO state, rr_ptr and icon_instr_dispatch_ready_i, so valid is never asserted to a full queue.
- Boundaries:
  - FIFO full or free space < NUM_DISPATCH_PORTS: fe_ready_o is low.
  - FIFO empty: no valid outputs.
  - All channel queues full: nothing is popped, rr_ptr is held.

## Configuration
- ICON_DISPATCH_SRC_AFFINITY_EN defined: each channel keeps a tag of the src_addr.euidx last dispatched to it.
  - If any channel with channel_active_i high holds a tag equal to the entry's euidx, the entry may go only to that channel.
  - If that channel is not ready or is already used this cycle, the walk stops at this entry.
  - This avoids tx_req_valid holds between channels in the controller.
  - The tag is written on every assignment.
- Not defined: plain round-robin. Tags and the channel_active_i logic are absent, and channel_active_i is ignored.

## Structure
- type_icon_instr, type_exec_unit_addr and type_icon_receivers_list come from pkg_dtypes.
- Add to pkg_dtypes: localparam ICON_DISPATCH_DEFAULT_PORTS.
- One sub-module: back_icon_dispatch_fifo, a multi-push/multi-pop circular buffer with push-count and pop-count inputs, exposing its first NUM_ICON_CHANNELS entries.
- The channel-assignment walk stays in the top module.

## Test plan
- Reset, then 2 valid ports with src euidx 1 and 2 and all channels ready → cycle+1: ch0 gets euidx 1, ch1 gets euidx 2; rr_ptr=2; occupancy 2 then 0.
- LOG2_STAGING_DEPTH=3, all channel ready_i low, 2 ports valid every cycle → 4 pushes; count reaches 8; fe_ready_o low once count ≥7; nothing popped.
- Only ch2 ready, 3 staged entries → only the head goes to ch2; 2 entries remain; rr_ptr=3.
- Head entry with receiver_list=0, next entry valid → head popped without dispatch; next entry goes to ch0; occupancy drops by 2.
- Affinity: ch1 active with tag euidx 5; new entry with euidx 5; ch1 not ready, ch0 ready → no dispatch until ch1 ready, then it goes to ch1. Without the macro → goes to ch0 immediately.
- Reset asserted with 5 entries staged → next cycle: occupancy 0, no valid outputs, fe_ready_o 1.

Source files
------------

// File: rtl/back_icon_dispatcher_pkg.sv
// Shared datatypes for the interconnect instruction path (pkg_dtypes slice).
// Defaults for the dispatcher's port count, channel count and staging depth live here too.
package pkg_dtypes;

  localparam int EU_IDX_W  = 4;
  localparam int CL_IDX_W  = 2;
  localparam int RECV_W    = 8;
  localparam int PAYLOAD_W = 8;

  localparam int ICON_DISPATCH_DEFAULT_PORTS      = 2;
  localparam int ICON_DISPATCH_DEFAULT_CHANNELS   = 4;
  localparam int ICON_DISPATCH_DEFAULT_LOG2_DEPTH = 3;

  typedef logic [RECV_W-1:0] type_icon_receivers_list;

  typedef struct packed {
    logic [CL_IDX_W-1:0] clidx;
    logic [EU_IDX_W-1:0] euidx;
  } type_exec_unit_addr;

  typedef struct packed {
    type_exec_unit_addr      src_addr;
    type_icon_receivers_list receiver_list;
    logic [PAYLOAD_W-1:0]    payload;
  } type_icon_instr;

endpackage

// File: rtl/back_icon_dispatcher_if.sv
// Front-end and controller-side signals of back_icon_dispatcher.
// master = dispatcher side, slave = front end plus controller side.
interface back_icon_dispatcher_if
  import pkg_dtypes::*;
#(
  parameter int NUM_DISPATCH_PORTS = ICON_DISPATCH_DEFAULT_PORTS,
  parameter int NUM_ICON_CHANNELS  = ICON_DISPATCH_DEFAULT_CHANNELS
);
  // Front end: fe_ready_o depends only on registered state, and when it is high
  // every asserted fe_valid_i port (contiguous from port 0) is taken that cycle.
  // Controller: a dispatch valid bit is a write strobe and is only raised for a
  // channel whose ready bit is high in that same cycle.
  type_icon_instr                fe_instr_i [NUM_DISPATCH_PORTS];
  logic [NUM_DISPATCH_PORTS-1:0] fe_valid_i;
  logic                          fe_ready_o;
  type_icon_instr                icon_instr_dispatch_o [NUM_ICON_CHANNELS];
  logic [NUM_ICON_CHANNELS-1:0]  icon_instr_dispatch_valid_o;
  logic [NUM_ICON_CHANNELS-1:0]  icon_instr_dispatch_ready_i;
  logic [NUM_ICON_CHANNELS-1:0]  channel_active_i;

  modport master (
    input  fe_instr_i, fe_valid_i, icon_instr_dispatch_ready_i, channel_active_i,
    output fe_ready_o, icon_instr_dispatch_o, icon_instr_dispatch_valid_o
  );

  modport slave (
    output fe_instr_i, fe_valid_i, icon_instr_dispatch_ready_i, channel_active_i,
    input  fe_ready_o, icon_instr_dispatch_o, icon_instr_dispatch_valid_o
  );

endinterface

// File: rtl/back_icon_dispatch_fifo.sv
// In-order staging buffer: up to NUM_PUSH writes and i_pop_cnt reads per cycle,
// with the first NUM_PEEK entries from the head visible combinationally.
module back_icon_dispatch_fifo
  import pkg_dtypes::*;
#(
  parameter int LOG2_DEPTH = 3,
  parameter int NUM_PUSH   = 2,
  parameter int NUM_PEEK   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [$clog2(NUM_PUSH+1)-1:0] i_push_cnt,
  input  type_icon_instr                i_push_data [NUM_PUSH],
  input  logic [$clog2(NUM_PEEK+1)-1:0] i_pop_cnt,
  output logic [LOG2_DEPTH:0]           o_count,
  output type_icon_instr                o_peek [NUM_PEEK]
);
  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int PTR_W  = LOG2_DEPTH;
  localparam int CNT_W  = LOG2_DEPTH + 1;
  localparam int PUSH_W = $clog2(NUM_PUSH + 1);

  type_icon_instr   r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Payload storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (PUSH_W'(i) < i_push_cnt) r_mem[r_wr_ptr + PTR_W'(i)] <= i_push_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_cnt);
      r_count  <= r_count + CNT_W'(i_push_cnt) - CNT_W'(i_pop_cnt);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PEEK; k++) o_peek[k] = r_mem[r_rd_ptr + PTR_W'(k)];
  end

  assign o_count = r_count;

endmodule

// File: rtl/back_icon_dispatcher.sv
// Steers staged interconnect instructions into controller channel queues, in order, round-robin.
// Optional macro ICON_DISPATCH_SRC_AFFINITY_EN pins a source euidx to the active channel that last took it.
module back_icon_dispatcher
  import pkg_dtypes::*;
#(
  parameter int NUM_ICON_CHANNELS  = ICON_DISPATCH_DEFAULT_CHANNELS,
  parameter int NUM_DISPATCH_PORTS = ICON_DISPATCH_DEFAULT_PORTS,
  parameter int LOG2_STAGING_DEPTH = ICON_DISPATCH_DEFAULT_LOG2_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  back_icon_dispatcher_if.master      bus,
  output logic [LOG2_STAGING_DEPTH:0] occupancy_o
);
  localparam int DEPTH  = 1 << LOG2_STAGING_DEPTH;
  localparam int CNT_W  = LOG2_STAGING_DEPTH + 1;
  localparam int PUSH_W = $clog2(NUM_DISPATCH_PORTS + 1);
  localparam int POP_W  = $clog2(NUM_ICON_CHANNELS + 1);
  localparam int CH_W   = (NUM_ICON_CHANNELS > 1) ? $clog2(NUM_ICON_CHANNELS) : 1;

  logic [CNT_W-1:0]             w_count;
  type_icon_instr               w_peek [NUM_ICON_CHANNELS];
  type_icon_instr               w_disp [NUM_ICON_CHANNELS];
  logic [NUM_ICON_CHANNELS-1:0] w_disp_valid;
  logic [NUM_ICON_CHANNELS-1:0] w_used;
  logic [PUSH_W-1:0]            w_push_cnt;
  logic [POP_W-1:0]             w_pop_cnt;
  logic                         w_fe_ready;
  logic                         w_stop;
  logic                         w_found;
  logic [CH_W-1:0]              w_sel;
  logic [CH_W-1:0]              r_rr_ptr;
  logic [CH_W-1:0]              w_rr_next;

`ifdef ICON_DISPATCH_SRC_AFFINITY_EN
  logic [EU_IDX_W-1:0]          r_tag [NUM_ICON_CHANNELS];
  logic [NUM_ICON_CHANNELS-1:0] r_tag_vld;
  logic [EU_IDX_W-1:0]          w_tag_d [NUM_ICON_CHANNELS];
  logic [NUM_ICON_CHANNELS-1:0] w_tag_we;
  logic                         w_pinned;
  logic [CH_W-1:0]              w_pin_ch;
`else
  logic w_unused_active;
  assign w_unused_active = ^bus.channel_active_i;
`endif

  function automatic logic [CH_W-1:0] wrap_ch(input int v);
    return CH_W'(v % NUM_ICON_CHANNELS);
  endfunction

  // Only registered count feeds ready, so the front end never sees a valid->ready loop.
  assign w_fe_ready     = (CNT_W'(DEPTH) - w_count) >= CNT_W'(NUM_DISPATCH_PORTS);
  assign bus.fe_ready_o = w_fe_ready;
  assign occupancy_o    = w_count;

  always_comb begin
    w_push_cnt = '0;
    if (w_fe_ready) begin
      for (int p = 0; p < NUM_DISPATCH_PORTS; p++) begin
        if (bus.fe_valid_i[p]) w_push_cnt = w_push_cnt + PUSH_W'(1);
      end
    end
  end

  back_icon_dispatch_fifo #(
    .LOG2_DEPTH (LOG2_STAGING_DEPTH),
    .NUM_PUSH   (NUM_DISPATCH_PORTS),
    .NUM_PEEK   (NUM_ICON_CHANNELS)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push_cnt  (w_push_cnt),
    .i_push_data (bus.fe_instr_i),
    .i_pop_cnt   (w_pop_cnt),
    .o_count     (w_count),
    .o_peek      (w_peek)
  );

  // Head-first walk; the first entry without a channel blocks everything behind it.
  always_comb begin
    w_disp_valid = '0;
    for (int c = 0; c < NUM_ICON_CHANNELS; c++) w_disp[c] = '0;
    w_pop_cnt = '0;
    w_used    = '0;
    w_stop    = !reset_n;
    w_found   = 1'b0;
    w_sel     = '0;
    w_rr_next = r_rr_ptr;
`ifdef ICON_DISPATCH_SRC_AFFINITY_EN
    w_pinned = 1'b0;
    w_pin_ch = '0;
    w_tag_we = '0;
    for (int c = 0; c < NUM_ICON_CHANNELS; c++) w_tag_d[c] = r_tag[c];
`endif
    for (int e = 0; e < NUM_ICON_CHANNELS; e++) begin
      if (!w_stop && (CNT_W'(e) < w_count)) begin
        if (w_peek[e].receiver_list == '0) begin
          w_pop_cnt = w_pop_cnt + POP_W'(1);
        end else begin
          w_found = 1'b0;
          w_sel   = '0;
`ifdef ICON_DISPATCH_SRC_AFFINITY_EN
          w_pinned = 1'b0;
          w_pin_ch = '0;
          for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
            if (!w_pinned && bus.channel_active_i[c] && r_tag_vld[c] &&
                (r_tag[c] == w_peek[e].src_addr.euidx)) begin
              w_pinned = 1'b1;
              w_pin_ch = CH_W'(c);
            end
          end
          if (w_pinned) begin
            if (bus.icon_instr_dispatch_ready_i[w_pin_ch] && !w_used[w_pin_ch]) begin
              w_found = 1'b1;
              w_sel   = w_pin_ch;
            end
          end else
`endif
          begin
            for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
              if (!w_found && bus.icon_instr_dispatch_ready_i[wrap_ch(int'(r_rr_ptr) + k)] &&
                  !w_used[wrap_ch(int'(r_rr_ptr) + k)]) begin
                w_found = 1'b1;
                w_sel   = wrap_ch(int'(r_rr_ptr) + k);
              end
            end
          end
          if (w_found) begin
            w_used[w_sel]       = 1'b1;
            w_disp_valid[w_sel] = 1'b1;
            w_disp[w_sel]       = w_peek[e];
            w_pop_cnt           = w_pop_cnt + POP_W'(1);
            w_rr_next           = wrap_ch(int'(w_sel) + 1);
`ifdef ICON_DISPATCH_SRC_AFFINITY_EN
            w_tag_we[w_sel] = 1'b1;
            w_tag_d[w_sel]  = w_peek[e].src_addr.euidx;
`endif
          end else begin
            w_stop = 1'b1;
          end
        end
      end
    end
  end

  assign bus.icon_instr_dispatch_o       = w_disp;
  assign bus.icon_instr_dispatch_valid_o = w_disp_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) r_rr_ptr <= '0;
    else          r_rr_ptr <= w_rr_next;
  end

`ifdef ICON_DISPATCH_SRC_AFFINITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      for (int c = 0; c < NUM_ICON_CHANNELS; c++) r_tag[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
        if (w_tag_we[c]) begin
          r_tag[c]     <= w_tag_d[c];
          r_tag_vld[c] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_back_icon_dispatcher.sv
// Directed bench for back_icon_dispatcher: staging, round-robin drain, skip of empty
// receiver lists, optional source affinity and mid-run reset.
module tb_back_icon_dispatcher;
  import pkg_dtypes::*;

  localparam int NCH  = 4;
  localparam int NP   = 2;
  localparam int LOG2 = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [LOG2:0] occupancy;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q [$];

  back_icon_dispatcher_if #(.NUM_DISPATCH_PORTS(NP), .NUM_ICON_CHANNELS(NCH)) bus ();

  back_icon_dispatcher #(
    .NUM_ICON_CHANNELS  (NCH),
    .NUM_DISPATCH_PORTS (NP),
    .LOG2_STAGING_DEPTH (LOG2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .occupancy_o (occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic type_icon_instr mk(input logic [3:0] eu, input logic [7:0] rl);
    type_icon_instr t;
    t = '0;
    t.src_addr.clidx = 2'd1;
    t.src_addr.euidx = eu;
    t.receiver_list  = rl;
    t.payload        = {4'ha, eu};
    return t;
  endfunction

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fe_valid_i = '0;
    bus.icon_instr_dispatch_ready_i = '0;
    bus.channel_active_i = '0;
    for (int p = 0; p < NP; p++) bus.fe_instr_i[p] = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] vld, input type_icon_instr a, input type_icon_instr b);
    bus.fe_instr_i[0] = a;
    bus.fe_instr_i[1] = b;
    bus.fe_valid_i = vld;
    tick();
    bus.fe_valid_i = '0;
  endtask

  logic [LOG2:0] fill_occ [6] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd8};
  logic          fill_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    clear_inputs();
    do_reset();
    #1;
    check_eq("rst_ready", bus.fe_ready_o, 1);
    check_eq("rst_valid", bus.icon_instr_dispatch_valid_o, 0);
    check_eq("rst_disp0", bus.icon_instr_dispatch_o[0], 0);
    check_eq("rst_occ", occupancy, 0);

    // two ports into an idle dispatcher; no bypass on the accept cycle
    bus.icon_instr_dispatch_ready_i = 4'b1111;
    bus.fe_instr_i[0] = mk(4'd1, 8'h01);
    bus.fe_instr_i[1] = mk(4'd2, 8'h01);
    bus.fe_valid_i = 2'b11;
    #1;
    check_eq("t1_nobypass", bus.icon_instr_dispatch_valid_o, 0);
    tick();
    bus.fe_valid_i = '0;
    #1;
    check_eq("t1_occ2", occupancy, 2);
    check_eq("t1_valid", bus.icon_instr_dispatch_valid_o, 4'b0011);
    check_eq("t1_ch0", bus.icon_instr_dispatch_o[0].src_addr.euidx, 1);
    check_eq("t1_ch1", bus.icon_instr_dispatch_o[1].src_addr.euidx, 2);
    check_eq("t1_ch2_zero", bus.icon_instr_dispatch_o[2], 0);
    tick();
    check_eq("t1_occ0", occupancy, 0);
    push(2'b01, mk(4'd9, 8'h01), '0);
    #1;
    check_eq("t1_rr2", bus.icon_instr_dispatch_valid_o, 4'b0100);
    check_eq("t1_rr2_data", bus.icon_instr_dispatch_o[2], mk(4'd9, 8'h01));

    // fill with every queue full
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(64'(2 * k));
      exp_q.push_back(64'(2 * k + 1));
    end
    for (int k = 0; k < 6; k++) begin
      bus.fe_instr_i[0] = mk(4'(2 * k), 8'h02);
      bus.fe_instr_i[1] = mk(4'(2 * k + 1), 8'h02);
      bus.fe_valid_i = 2'b11;
      #1;
      check_eq($sformatf("fill_occ%0d", k), occupancy, fill_occ[k]);
      check_eq($sformatf("fill_rdy%0d", k), bus.fe_ready_o, fill_rdy[k]);
      check_eq($sformatf("fill_nodisp%0d", k), bus.icon_instr_dispatch_valid_o, 0);
      tick();
    end
    bus.fe_valid_i = '0;
    bus.icon_instr_dispatch_ready_i = 4'b1111;
    #1;
    check_eq("drain1_valid", bus.icon_instr_dispatch_valid_o, 4'b1111);
    for (int c = 0; c < NCH; c++)
      check_eq("drain1_order", bus.icon_instr_dispatch_o[c].src_addr.euidx, exp_q.pop_front());
    tick();
    check_eq("drain1_occ", occupancy, 4);
    for (int c = 0; c < NCH; c++)
      check_eq("drain2_order", bus.icon_instr_dispatch_o[c].src_addr.euidx, exp_q.pop_front());
    tick();
    check_eq("drain2_occ", occupancy, 0);

    // single ready channel takes only the head
    do_reset();
    push(2'b11, mk(4'd1, 8'h01), mk(4'd2, 8'h01));
    push(2'b01, mk(4'd3, 8'h01), '0);
    bus.icon_instr_dispatch_ready_i = 4'b0100;
    #1;
    check_eq("t3_occ3", occupancy, 3);
    check_eq("t3_valid", bus.icon_instr_dispatch_valid_o, 4'b0100);
    check_eq("t3_ch2", bus.icon_instr_dispatch_o[2].src_addr.euidx, 1);
    tick();
    check_eq("t3_occ2", occupancy, 2);
    bus.icon_instr_dispatch_ready_i = 4'b1111;
    #1;
    check_eq("t3_rr3_valid", bus.icon_instr_dispatch_valid_o, 4'b1001);
    check_eq("t3_ch3", bus.icon_instr_dispatch_o[3].src_addr.euidx, 2);
    check_eq("t3_ch0", bus.icon_instr_dispatch_o[0].src_addr.euidx, 3);

    // empty receiver list at the head is dropped
    do_reset();
    push(2'b11, mk(4'd7, 8'h00), mk(4'd8, 8'h04));
    #1;
    check_eq("t4_occ2", occupancy, 2);
    bus.icon_instr_dispatch_ready_i = 4'b1111;
    #1;
    check_eq("t4_valid", bus.icon_instr_dispatch_valid_o, 4'b0001);
    check_eq("t4_ch0", bus.icon_instr_dispatch_o[0], mk(4'd8, 8'h04));
    check_eq("t4_ch1_zero", bus.icon_instr_dispatch_o[1], 0);
    tick();
    check_eq("t4_occ0", occupancy, 0);

    // source affinity
    do_reset();
    bus.icon_instr_dispatch_ready_i = 4'b0010;
    push(2'b01, mk(4'd5, 8'h01), '0);
    #1;
    check_eq("t5_first_ch1", bus.icon_instr_dispatch_valid_o, 4'b0010);
    tick();
    bus.channel_active_i = 4'b0010;
    bus.icon_instr_dispatch_ready_i = 4'b0001;
    push(2'b01, mk(4'd5, 8'h01), '0);
    #1;
`ifdef ICON_DISPATCH_SRC_AFFINITY_EN
    check_eq("t5_aff_hold", bus.icon_instr_dispatch_valid_o, 0);
    tick();
    check_eq("t5_aff_occ1", occupancy, 1);
    bus.icon_instr_dispatch_ready_i = 4'b0011;
    #1;
    check_eq("t5_aff_valid", bus.icon_instr_dispatch_valid_o, 4'b0010);
    check_eq("t5_aff_ch1", bus.icon_instr_dispatch_o[1].src_addr.euidx, 5);
`else
    check_eq("t5_rr_valid", bus.icon_instr_dispatch_valid_o, 4'b0001);
    check_eq("t5_rr_ch0", bus.icon_instr_dispatch_o[0].src_addr.euidx, 5);
`endif
    tick();
    check_eq("t5_occ0", occupancy, 0);

    // reset with five entries staged
    do_reset();
    push(2'b11, mk(4'd1, 8'h01), mk(4'd2, 8'h01));
    push(2'b11, mk(4'd3, 8'h01), mk(4'd4, 8'h01));
    push(2'b01, mk(4'd5, 8'h01), '0);
    #1;
    check_eq("t6_occ5", occupancy, 5);
    reset_n = 1'b0;
    bus.icon_instr_dispatch_ready_i = 4'b1111;
    #1;
    check_eq("t6_rst_nodisp", bus.icon_instr_dispatch_valid_o, 0);
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("t6_occ0", occupancy, 0);
    check_eq("t6_valid0", bus.icon_instr_dispatch_valid_o, 0);
    check_eq("t6_ready1", bus.fe_ready_o, 1);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
